// File: rtl/avmm_rw_pkg.sv
// -----------------------------------------------------------------------------
// avmm_rw_pkg
//   Shared types and helpers for the Avalon-MM read/write responder.
//   - avmm_req_t : one cycle's worth of master request signals.
//   - win_t      : result of the address-window decode {hit, idx}.
//   - in_window  : byte address -> {in-range, word index}.
//   - sat_inc    : saturating counter step with a synchronous clear.
//   The bus and memory geometry constants below size the request struct and
//   the decode. The top checks at elaboration that its parameters agree.
// -----------------------------------------------------------------------------
package avmm_rw_pkg;

    localparam int AVMM_DATA_W      = 64;
    localparam int AVMM_BE_W        = AVMM_DATA_W / 8;
    localparam int AVMM_ADDR_W      = 64;
    localparam int AVMM_DEPTH_WORDS = 1024;
    localparam int CNT_W            = 32;

    localparam int WORD_LSB = $clog2(AVMM_BE_W);
    localparam int IDX_W    = $clog2(AVMM_DEPTH_WORDS);

    // Size of the decoded window in bytes.
    localparam logic [AVMM_ADDR_W-1:0] WINDOW_BYTES =
        AVMM_ADDR_W'(AVMM_DEPTH_WORDS * AVMM_BE_W);

    typedef struct packed {
        logic [AVMM_ADDR_W-1:0] addr;
        logic [AVMM_BE_W-1:0]   be;
        logic                   rd;
        logic                   wr;
        logic [AVMM_DATA_W-1:0] wdata;
    } avmm_req_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } win_t;

    // The window test is done on the offset from the base rather than on
    // base + size, so a window placed at the top of the address space
    // cannot wrap and produce a false hit.
    function automatic win_t in_window(input logic [AVMM_ADDR_W-1:0] addr,
                                       input logic [AVMM_ADDR_W-1:0] base);
        win_t                   w;
        logic [AVMM_ADDR_W-1:0] off;
        off   = addr - base;
        w.hit = (addr >= base) && (off < WINDOW_BYTES);
        // Byte-within-word bits are dropped; sub-word addresses alias to
        // their containing word.
        w.idx = IDX_W'(off >> WORD_LSB);
        return w;
    endfunction

    // A clear in the same cycle as an access leaves the counter at 1, so the
    // access that coincides with the clear is not lost.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc,
                                                 input logic             clr);
        if (clr)
            return CNT_W'(inc);
        else if (inc && (cnt != '1))
            return cnt + 1'b1;
        else
            return cnt;
    endfunction

endpackage

// File: rtl/avmm_rw_responder_rd_pipe.sv
// -----------------------------------------------------------------------------
// avmm_rd_pipe
//   Delay line that stretches the read response from the registered RAM read
//   out to the configured read latency. STAGES = READ_LATENCY - 1; with zero
//   stages the response passes straight through.
//   Each data stage only loads when its incoming valid is set, so the output
//   data holds the last returned word while valid is low.
//
//   Ports
//     clock, resetn        : clock and asynchronous active-low reset
//     in_valid, in_data    : response from the RAM read stage
//     out_valid, out_data  : response presented to the bus
// -----------------------------------------------------------------------------
module avmm_rd_pipe #(
    parameter int DATA_W = 64,
    parameter int STAGES = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ resetn;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_delay
            logic [STAGES-1:0] valid_q;
            logic [DATA_W-1:0] data_q [STAGES];

            // NOTE: state registers use non-blocking assignments so every
            // stage samples its predecessor's pre-edge value; blocking
            // assignments here would collapse the delay line to one stage.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    valid_q <= '0;
                    for (int i = 0; i < STAGES; i++)
                        data_q[i] <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    if (in_valid)
                        data_q[0] <= in_data;
                    for (int i = 1; i < STAGES; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        if (valid_q[i-1])
                            data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/avmm_rw_responder.sv
// -----------------------------------------------------------------------------
// avmm_rw_responder
//   Avalon-MM responder for an HLS component's fixed-latency read/write master.
//   Terminates the bus in a byte-addressed on-chip word memory with byte-lane
//   writes, and keeps access counters plus sticky error flags for the harness.
//   There is no waitrequest: every read/write is accepted in its cycle.
//
//   Ports
//     clock, resetn           : clock; asynchronous active-low reset
//     avmm_rw_address         : byte address (low WORD_LSB bits ignored)
//     avmm_rw_byteenable      : write byte-lane enables
//     avmm_rw_read/_write     : one request per asserted cycle
//     avmm_rw_writedata       : write data
//     avmm_rw_readdata        : read data, READ_LATENCY cycles after request
//     avmm_rw_readdatavalid   : qualifies readdata
//     stat_clear              : synchronous clear of counters and flags
//     rd_count, wr_count      : saturating accepted-access counters
//     oor_error               : sticky, access outside the memory window
//     rw_conflict             : sticky, read and write in the same cycle
//
//   Width and depth parameters must match the avmm_rw_pkg geometry constants;
//   BASE_ADDR, READ_LATENCY and OOR_DATA are free.
// -----------------------------------------------------------------------------
module avmm_rw_responder
    import avmm_rw_pkg::*;
#(
    parameter int                 DATA_W       = AVMM_DATA_W,
    parameter int                 BE_W         = DATA_W / 8,
    parameter int                 ADDR_W       = AVMM_ADDR_W,
    parameter int                 DEPTH_WORDS  = AVMM_DEPTH_WORDS,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
    parameter int                 READ_LATENCY = 1,
    parameter logic [DATA_W-1:0]  OOR_DATA     = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] avmm_rw_address,
    input  logic [BE_W-1:0]   avmm_rw_byteenable,
    input  logic              avmm_rw_read,
    output logic [DATA_W-1:0] avmm_rw_readdata,
    output logic              avmm_rw_readdatavalid,
    input  logic              avmm_rw_write,
    input  logic [DATA_W-1:0] avmm_rw_writedata,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              oor_error,
    output logic              rw_conflict
);

    generate
        if (DATA_W != AVMM_DATA_W || BE_W != AVMM_BE_W || ADDR_W != AVMM_ADDR_W ||
            DEPTH_WORDS != AVMM_DEPTH_WORDS) begin : g_bad_geometry
            $error("avmm_rw_responder: geometry parameters differ from avmm_rw_pkg");
        end
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("avmm_rw_responder: READ_LATENCY must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on the first clock edge after
    // resetn rises, so an access on the second edge is captured.
    // ------------------------------------------------------------------
    logic rst_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            rst_n <= 1'b0;
        else
            rst_n <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Request capture and address decode
    // ------------------------------------------------------------------
    avmm_req_t req;
    win_t      win;

    assign req.addr  = avmm_rw_address;
    assign req.be    = avmm_rw_byteenable;
    assign req.rd    = avmm_rw_read;
    assign req.wr    = avmm_rw_write;
    assign req.wdata = avmm_rw_writedata;

    assign win = in_window(req.addr, BASE_ADDR);

    logic wr_en;
    logic rd_en;

    // Writes are held off until the synchronised reset has released so a
    // request straddling reset cannot half-land in memory.
    assign wr_en = req.wr & win.hit & rst_n;
    assign rd_en = req.rd & win.hit;

    // ------------------------------------------------------------------
    // Byte-lane word memory
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] ram_q;

    // NOTE: the memory and its read register carry no reset: contents must
    // survive reset, and a reset on a RAM array prevents block-RAM mapping.
    // The read sits in the same non-blocking block as the write, so a read
    // and write to one word in one cycle returns the pre-write data.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req.be[i])
                    mem[win.idx][i*8 +: 8] <= req.wdata[i*8 +: 8];
            end
        end
        if (rd_en)
            ram_q <= mem[win.idx];
    end

    // Resettable companions of ram_q: whether any read has returned since
    // reset (readdata is 0 until then) and whether the last read missed.
    logic rd_valid_q;
    logic rd_seen_q;
    logic rd_oor_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= req.rd;
            if (req.rd) begin
                rd_seen_q <= 1'b1;
                rd_oor_q  <= ~win.hit;
            end
        end
    end

    logic [DATA_W-1:0] rd_data_s0;

    assign rd_data_s0 = !rd_seen_q ? '0       :
                        rd_oor_q   ? OOR_DATA : ram_q;

    avmm_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clock     (clock),
        .resetn    (rst_n),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_s0),
        .out_valid (avmm_rw_readdatavalid),
        .out_data  (avmm_rw_readdata)
    );

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic oor_hit;
    logic conflict_hit;

    assign oor_hit      = (req.rd | req.wr) & ~win.hit;
    assign conflict_hit = req.rd & req.wr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_count    <= '0;
            wr_count    <= '0;
            oor_error   <= 1'b0;
            rw_conflict <= 1'b0;
        end else begin
            rd_count    <= sat_inc(rd_count, req.rd, stat_clear);
            wr_count    <= sat_inc(wr_count, req.wr, stat_clear);
            oor_error   <= stat_clear ? oor_hit      : (oor_error   | oor_hit);
            rw_conflict <= stat_clear ? conflict_hit : (rw_conflict | conflict_hit);
        end
    end

endmodule

// File: tb/tb_avmm_rw_responder.sv
// -----------------------------------------------------------------------------
// tb_avmm_rw_responder
//   Directed bench. Two responders share one request bus: u_lat1 with
//   READ_LATENCY=1 and u_lat3 with READ_LATENCY=3. Inputs change 1 ns after a
//   rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_avmm_rw_responder;

    localparam logic [63:0] OOR  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] D1   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] TOP  = 64'd8192;   // BASE + DEPTH_WORDS*8

    logic        clock = 1'b0;
    logic        resetn;
    logic [63:0] address;
    logic [7:0]  byteenable;
    logic        read;
    logic        write;
    logic [63:0] writedata;
    logic        stat_clear;

    logic [63:0] l1_rdata,  l3_rdata;
    logic        l1_rvalid, l3_rvalid;
    logic [31:0] l1_rdcnt,  l3_rdcnt;
    logic [31:0] l1_wrcnt,  l3_wrcnt;
    logic        l1_oor,    l3_oor;
    logic        l1_conf,   l3_conf;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    avmm_rw_responder #(.READ_LATENCY(1)) u_lat1 (
        .clock                 (clock),
        .resetn                (resetn),
        .avmm_rw_address       (address),
        .avmm_rw_byteenable    (byteenable),
        .avmm_rw_read          (read),
        .avmm_rw_readdata      (l1_rdata),
        .avmm_rw_readdatavalid (l1_rvalid),
        .avmm_rw_write         (write),
        .avmm_rw_writedata     (writedata),
        .stat_clear            (stat_clear),
        .rd_count              (l1_rdcnt),
        .wr_count              (l1_wrcnt),
        .oor_error             (l1_oor),
        .rw_conflict           (l1_conf)
    );

    avmm_rw_responder #(.READ_LATENCY(3)) u_lat3 (
        .clock                 (clock),
        .resetn                (resetn),
        .avmm_rw_address       (address),
        .avmm_rw_byteenable    (byteenable),
        .avmm_rw_read          (read),
        .avmm_rw_readdata      (l3_rdata),
        .avmm_rw_readdatavalid (l3_rvalid),
        .avmm_rw_write         (write),
        .avmm_rw_writedata     (writedata),
        .stat_clear            (stat_clear),
        .rd_count              (l3_rdcnt),
        .wr_count              (l3_wrcnt),
        .oor_error             (l3_oor),
        .rw_conflict           (l3_conf)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [7:0] be, input logic [63:0] wdata,
                         input logic clr);
        read       = rd;
        write      = wr;
        address    = addr;
        byteenable = be;
        writedata  = wdata;
        stat_clear = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_5A5A_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        resetn = 1'b0;
        idle();
        repeat (3) step();
        check("rst_l1_rdata",  l1_rdata,         64'h0);
        check("rst_l1_rvalid", 64'(l1_rvalid),   64'h0);
        check("rst_l3_rvalid", 64'(l3_rvalid),   64'h0);
        check("rst_rdcnt",     64'(l1_rdcnt),    64'h0);
        check("rst_wrcnt",     64'(l1_wrcnt),    64'h0);
        check("rst_oor",       64'(l1_oor),      64'h0);
        check("rst_conf",      64'(l1_conf),     64'h0);
        resetn = 1'b1;
        repeat (3) step();

        // ---------------- full write then read, LAT=1 ----------------
        drive(1'b0, 1'b1, 64'h0, 8'hFF, D1, 1'b0);
        step();
        drive(1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        step();
        check("rw0_l1_valid", 64'(l1_rvalid), 64'h1);
        check("rw0_l1_data",  l1_rdata,       D1);
        idle();
        step();
        check("rw0_pulse_width", 64'(l1_rvalid), 64'h0);
        check("rw0_data_hold",   l1_rdata,       D1);

        // ---------------- partial write to word 1 ----------------
        drive(1'b0, 1'b1, 64'h8, 8'hFF, D1, 1'b0);
        step();
        drive(1'b0, 1'b1, 64'h8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
        step();
        drive(1'b1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0);
        step();
        check("partial_be", l1_rdata, 64'h1122_3344_BBBB_BBBB);

        // byteenable=0 writes nothing but counts
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
        step();
        drive(1'b0, 1'b1, 64'h8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        drive(1'b1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0);
        step();
        check("be0_no_write", l1_rdata,       64'h1122_3344_BBBB_BBBB);
        check("be0_wrcnt",    64'(l1_wrcnt),  64'h1);

        // ---------------- 8 back-to-back reads, LAT=3 ----------------
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 64'(i) * 64'd8, 8'hFF, pat(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
        step();
        check("clr_rdcnt", 64'(l3_rdcnt), 64'h0);
        check("clr_wrcnt", 64'(l3_wrcnt), 64'h0);
        for (int t = 0; t < 10; t++) begin
            if (t < 8)
                drive(1'b1, 1'b0, 64'(t) * 64'd8, 8'h00, 64'h0, 1'b0);
            else
                idle();
            step();
            if (t >= 2) begin
                check($sformatf("burst_valid_%0d", t - 2), 64'(l3_rvalid), 64'h1);
                check($sformatf("burst_data_%0d",  t - 2), l3_rdata,       pat(t - 2));
            end else begin
                check($sformatf("burst_early_%0d", t), 64'(l3_rvalid), 64'h0);
            end
        end
        step();
        check("burst_end_valid", 64'(l3_rvalid), 64'h0);
        check("burst_rdcnt",     64'(l3_rdcnt),  64'h8);

        // ---------------- window boundaries ----------------
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
        step();
        drive(1'b0, 1'b1, TOP - 64'd8, 8'hFF, 64'h0BAD_F00D_1234_5678, 1'b0);
        step();
        drive(1'b1, 1'b0, TOP - 64'd8, 8'h00, 64'h0, 1'b0);
        step();
        check("last_word_data", l1_rdata,     64'h0BAD_F00D_1234_5678);
        check("last_word_oor",  64'(l1_oor),  64'h0);
        drive(1'b1, 1'b0, TOP, 8'h00, 64'h0, 1'b0);
        step();
        check("oor_read_data", l1_rdata,        OOR);
        check("oor_read_flag", 64'(l1_oor),     64'h1);
        check("oor_read_valid", 64'(l1_rvalid), 64'h1);
        drive(1'b0, 1'b1, TOP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        // Address 3 lies inside word 0; the out-of-range write aliases word 0.
        drive(1'b1, 1'b0, 64'h3, 8'h00, 64'h0, 1'b0);
        step();
        check("oor_write_no_change", l1_rdata,    pat(0));
        check("oor_flag_sticky",     64'(l1_oor), 64'h1);

        // ---------------- read+write same cycle, with stat_clear ----------------
        drive(1'b0, 1'b1, 64'd40, 8'hFF, 64'h1, 1'b0);
        step();
        drive(1'b1, 1'b1, 64'd40, 8'hFF, 64'h2, 1'b1);
        step();
        check("conflict_old_data", l1_rdata,       64'h1);
        check("conflict_flag",     64'(l1_conf),   64'h1);
        check("conflict_rdcnt",    64'(l1_rdcnt),  64'h1);
        check("conflict_wrcnt",    64'(l1_wrcnt),  64'h1);
        check("conflict_oor_clr",  64'(l1_oor),    64'h0);
        drive(1'b1, 1'b0, 64'd40, 8'h00, 64'h0, 1'b0);
        step();
        check("conflict_new_data", l1_rdata, 64'h2);

        // ---------------- reset with reads in flight, LAT=3 ----------------
        drive(1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        step();
        drive(1'b1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0);
        step();
        idle();
        resetn = 1'b0;
        #1;
        check("inflight_rst_valid", 64'(l3_rvalid), 64'h0);
        check("inflight_rst_data",  l3_rdata,       64'h0);
        check("inflight_rst_rdcnt", 64'(l3_rdcnt),  64'h0);
        check("inflight_rst_conf",  64'(l1_conf),   64'h0);
        step();
        step();
        resetn = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("post_rst_quiet_%0d", t), 64'(l3_rvalid), 64'h0);
        end
        drive(1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        step();
        check("mem_kept_l1", l1_rdata, pat(0));
        idle();
        step();
        step();
        check("mem_kept_l3_valid", 64'(l3_rvalid), 64'h1);
        check("mem_kept_l3_data",  l3_rdata,       pat(0));
        check("post_rst_rdcnt",    64'(l3_rdcnt),  64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
